button_pulse_gen: RTL

//  Producer side of the per-button tick interface the clock/calendar core consumes.

---
 rtl/button_pulse_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/button_pulse_gen.sv
// Conditions one raw active-low push button into a debounced level, a press strobe
// and optional auto-repeat strobes for the clock/calendar tick inputs.
module button_pulse_gen #(
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       butt_n,
  input  logic       repeat_en,
  output logic       pulse,
  output logic       pressed,
  output logic       held,
  output logic [2:0] dbg_state
);

  // pulse is a one-cycle strobe with no ready: the consumer must sample it every cycle.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pulse;
  logic             r_pressed;
  logic             r_held;
  logic             w_pulse_nxt;
  logic             w_pressed_nxt;
  logic             w_held_nxt;
  logic             w_s;

  assign w_s       = r_sync2;
  assign pulse     = r_pulse;
  assign pressed   = r_pressed;
  assign held      = r_held;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_pressed <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_sync1   <= butt_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_pressed <= w_pressed_nxt;
      r_held    <= w_held_nxt;
    end
  end

  // Release (s=1) is tested first in every pressed state so it beats repeat_en drop and expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
    w_pressed_nxt = r_pressed;
    w_held_nxt    = r_held;
    case (r_state)
      IDLE: begin
        if (!w_s) begin
          w_state_nxt = PRESS_DB;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_DB_LAST) begin
          w_state_nxt   = HELD;
          w_cnt_nxt     = '0;
          w_pulse_nxt   = 1'b1;
          w_pressed_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (w_s) begin
          w_state_nxt = RELEASE_DB;
          w_cnt_nxt   = '0;
        end else if (repeat_en && (r_cnt == L_HOLD_LAST)) begin
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
          w_held_nxt  = 1'b1;
        end else if (r_cnt != L_HOLD_LAST) begin
          // Saturates so enabling repeat after a long hold fires immediately.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (w_s) begin
          w_state_nxt = RELEASE_DB;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b0;
        end else if (!repeat_en) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b0;
        end else if (r_cnt == L_REP_LAST) begin
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      RELEASE_DB: begin
        if (!w_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_DB_LAST) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
